// File: rtl/ddr_params.sv
// Shared SDRAM definitions for the read engine: command encodings,
// idle bus values, linear address field positions and FSM states.
package ddr_params;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
  localparam logic [3:0] CMD_READ      = 4'b0101;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;

  // Bus values driven whenever no command is being issued
  localparam logic [1:0]  NOP_BA       = 2'b11;
  localparam logic [12:0] NOP_ADDR     = 13'h1fff;
  // A10=1 selects all banks for PRECHARGE
  localparam logic [12:0] PRE_ALL_ADDR = 13'h0400;

  // Linear address layout {bank, row, col}
  localparam int BA_MSB  = 23;
  localparam int BA_LSB  = 22;
  localparam int ROW_MSB = 21;
  localparam int ROW_LSB = 9;
  localparam int COL_MSB = 8;
  localparam int COL_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACT,
    ST_TRCD_W,
    ST_RD,
    ST_RD_W,
    ST_PRE,
    ST_TRP_W,
    ST_END
  } rd_state_e;

  function automatic logic [1:0] addr_bank(input logic [23:0] a);
    return a[BA_MSB:BA_LSB];
  endfunction

  function automatic logic [12:0] addr_row(input logic [23:0] a);
    return a[ROW_MSB:ROW_LSB];
  endfunction

  // Column on the address bus with A10=0, so READ never auto-precharges
  function automatic logic [12:0] addr_col(input logic [23:0] a);
    return {4'b0000, a[COL_MSB:COL_LSB]};
  endfunction

endpackage

// File: rtl/ddr_rd_capture.sv
// Read data capture: registers the SDRAM dq bus every cycle and produces
// a valid window of BURST_LEN cycles that lines up with the burst data
// returned CAS_LAT cycles after the READ command.
module ddr_rd_capture #(
  parameter int CAS_LAT   = 3,
  parameter int BURST_LEN = 8
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        i_rd_issue,  // high during the cycle READ is on the bus
  input  logic [15:0] i_dq,
  output logic [15:0] o_data,
  output logic        o_valid
);

  // Bit k of the shift register is high k+1 cycles after the READ cycle.
  // The upper BURST_LEN taps form the valid window once registered.
  localparam int SR_LEN = CAS_LAT + BURST_LEN - 1;

  logic [SR_LEN-1:0] r_sr;
  logic [15:0]       r_data;
  logic              r_valid;
  logic              w_win;

  assign w_win   = |r_sr[SR_LEN-1:CAS_LAT-1];
  assign o_data  = r_data;
  assign o_valid = r_valid;

  // Track the age of the READ command and register the valid window
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_sr    <= '0;
      r_valid <= 1'b0;
    end else begin
      r_sr    <= {r_sr[SR_LEN-2:0], i_rd_issue};
      r_valid <= w_win;
    end
  end

  // Free-running dq capture; o_valid says which words belong to the burst
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_data <= '0;
    end else begin
      r_data <= i_dq;
    end
  end

endmodule

// File: rtl/ddr_ctrl_read.sv
// SDRAM controller read engine: accepts a user read trigger, requests the
// bus from the arbiter and, once granted, runs ACTIVE / READ / PRECHARGE
// with the configured timing while capturing the returned burst.
module ddr_ctrl_read
  import ddr_params::*;
#(
  parameter int TRCD      = 2,
  parameter int CAS_LAT   = 3,
  parameter int BURST_LEN = 8,
  parameter int TRP       = 2,
  parameter int CNT_W     = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        init_end_i,
  input  logic        rd_trig_i,
  input  logic [23:0] rd_addr_i,
  input  logic        rd_en_i,
  input  logic [15:0] sdram_dq_i,
  output logic        rd_req_o,
  output logic        rd_end_o,
  output logic [3:0]  rd_cmd_o,
  output logic [1:0]  rd_ba_o,
  output logic [12:0] rd_addr_o,
  output logic [15:0] rd_data_o,
  output logic        rd_data_valid_o,
  output logic        rd_busy_o
);

  // Terminal counts of the wait states; the counter starts at 0 on entry.
  // The guarded values are never compared when the wait state is skipped.
  localparam int TRCD_TC = (TRCD > 1) ? TRCD - 2 : 0;
  localparam int RDW_TC  = CAS_LAT + BURST_LEN - 1;
  localparam int TRP_TC  = (TRP > 1) ? TRP - 2 : 0;

  rd_state_e         r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [23:0]       r_addr_lat;
  logic              r_req;
  logic              r_end;
  logic              r_busy;
  logic [3:0]        r_cmd;
  logic [1:0]        r_ba;
  logic [12:0]       r_addr;
  logic              w_rd_issue;

  assign rd_req_o  = r_req;
  assign rd_end_o  = r_end;
  assign rd_busy_o = r_busy;
  assign rd_cmd_o  = r_cmd;
  assign rd_ba_o   = r_ba;
  assign rd_addr_o = r_addr;

  assign w_rd_issue = (r_state == ST_RD);

  // Access sequencer: state, wait counter and all registered bus outputs
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_addr_lat <= '0;
      r_req      <= 1'b0;
      r_end      <= 1'b0;
      r_busy     <= 1'b0;
      r_cmd      <= CMD_NOP;
      r_ba       <= NOP_BA;
      r_addr     <= NOP_ADDR;
    end else begin
      // Every cycle is a NOP unless a state below issues a command
      r_cmd  <= CMD_NOP;
      r_ba   <= NOP_BA;
      r_addr <= NOP_ADDR;
      r_end  <= 1'b0;
      r_cnt  <= r_cnt + 1'b1;

      // Single-entry acceptance: triggers while busy are simply dropped
      if (rd_trig_i && init_end_i && !r_busy) begin
        r_addr_lat <= rd_addr_i;
        r_busy     <= 1'b1;
        r_req      <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (r_req && rd_en_i) begin
            r_state <= ST_ACT;
            r_req   <= 1'b0;
            r_cmd   <= CMD_ACTIVE;
            r_ba    <= addr_bank(r_addr_lat);
            r_addr  <= addr_row(r_addr_lat);
          end
        end

        ST_ACT: begin
          r_cnt <= '0;
          if (TRCD > 1) begin
            r_state <= ST_TRCD_W;
          end else begin
            r_state <= ST_RD;
            r_cmd   <= CMD_READ;
            r_ba    <= addr_bank(r_addr_lat);
            r_addr  <= addr_col(r_addr_lat);
          end
        end

        ST_TRCD_W: begin
          if (r_cnt == CNT_W'(TRCD_TC)) begin
            r_cnt   <= '0;
            r_state <= ST_RD;
            r_cmd   <= CMD_READ;
            r_ba    <= addr_bank(r_addr_lat);
            r_addr  <= addr_col(r_addr_lat);
          end
        end

        ST_RD: begin
          r_cnt   <= '0;
          r_state <= ST_RD_W;
        end

        ST_RD_W: begin
          if (r_cnt == CNT_W'(RDW_TC)) begin
            r_cnt   <= '0;
            r_state <= ST_PRE;
            r_cmd   <= CMD_PRECHARGE;
            r_ba    <= addr_bank(r_addr_lat);
            r_addr  <= PRE_ALL_ADDR;
          end
        end

        ST_PRE: begin
          r_cnt <= '0;
          if (TRP > 1) begin
            r_state <= ST_TRP_W;
          end else begin
            r_state <= ST_END;
            r_end   <= 1'b1;
          end
        end

        ST_TRP_W: begin
          if (r_cnt == CNT_W'(TRP_TC)) begin
            r_cnt   <= '0;
            r_state <= ST_END;
            r_end   <= 1'b1;
          end
        end

        ST_END: begin
          r_cnt   <= '0;
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  ddr_rd_capture #(
    .CAS_LAT   (CAS_LAT),
    .BURST_LEN (BURST_LEN)
  ) u_capture (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .i_rd_issue (w_rd_issue),
    .i_dq       (sdram_dq_i),
    .o_data     (rd_data_o),
    .o_valid    (rd_data_valid_o)
  );

endmodule

// File: tb/tb_ddr_ctrl_read.sv
// Bench for the SDRAM read engine: a default-parameter instance and a
// TRCD=3/CAS_LAT=2/BURST_LEN=4 instance, driven from a vector table and
// randomized accesses, plus hand sequences for reset, missing grant and
// init_end low.
module tb_ddr_ctrl_read;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] RD  = 4'b0101;
  localparam logic [3:0] PRE = 4'b0010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init_end = 1'b1;
  logic [23:0] addr_in = '0;
  logic [15:0] dq = '0;
  logic        trig_a = 1'b0, trig_b = 1'b0;
  logic        en_a = 1'b0, en_b = 1'b0;

  logic        a_req, a_end, a_valid, a_busy;
  logic [3:0]  a_cmd;
  logic [1:0]  a_ba;
  logic [12:0] a_addr;
  logic [15:0] a_data;
  logic        b_req, b_end, b_valid, b_busy;
  logic [3:0]  b_cmd;
  logic [1:0]  b_ba;
  logic [12:0] b_addr;
  logic [15:0] b_data;

  int cur = 0;
  logic        m_req, m_end, m_valid, m_busy;
  logic [3:0]  m_cmd;
  logic [1:0]  m_ba;
  logic [12:0] m_addr;
  logic [15:0] m_data;

  assign m_req   = (cur == 0) ? a_req   : b_req;
  assign m_end   = (cur == 0) ? a_end   : b_end;
  assign m_valid = (cur == 0) ? a_valid : b_valid;
  assign m_busy  = (cur == 0) ? a_busy  : b_busy;
  assign m_cmd   = (cur == 0) ? a_cmd   : b_cmd;
  assign m_ba    = (cur == 0) ? a_ba    : b_ba;
  assign m_addr  = (cur == 0) ? a_addr  : b_addr;
  assign m_data  = (cur == 0) ? a_data  : b_data;

  always #5 clk = ~clk;

  ddr_ctrl_read u_a (
    .sys_clk(clk), .sys_rst(rst), .init_end_i(init_end), .rd_trig_i(trig_a),
    .rd_addr_i(addr_in), .rd_en_i(en_a), .sdram_dq_i(dq),
    .rd_req_o(a_req), .rd_end_o(a_end), .rd_cmd_o(a_cmd), .rd_ba_o(a_ba),
    .rd_addr_o(a_addr), .rd_data_o(a_data), .rd_data_valid_o(a_valid),
    .rd_busy_o(a_busy)
  );

  ddr_ctrl_read #(.TRCD(3), .CAS_LAT(2), .BURST_LEN(4), .TRP(2), .CNT_W(4)) u_b (
    .sys_clk(clk), .sys_rst(rst), .init_end_i(init_end), .rd_trig_i(trig_b),
    .rd_addr_i(addr_in), .rd_en_i(en_b), .sdram_dq_i(dq),
    .rd_req_o(b_req), .rd_end_o(b_end), .rd_cmd_o(b_cmd), .rd_ba_o(b_ba),
    .rd_addr_o(b_addr), .rd_data_o(b_data), .rd_data_valid_o(b_valid),
    .rd_busy_o(b_busy)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] last_dq = '0;

  typedef struct {
    int          sel;
    logic [23:0] addr;
    int          gdly;
    bit          tmid;
    bit          drop;
    logic [1:0]  ba;
    logic [12:0] row;
    logic [8:0]  col;
    int          rd_c;
    int          pre_c;
    int          end_c;
    int          vf;
    int          vl;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive_dq();
    dq = 16'($urandom);
    last_dq = dq;
  endtask

  task automatic set_trig(input int sel, input logic v);
    if (sel == 0) trig_a = v; else trig_b = v;
  endtask

  task automatic set_en(input int sel, input logic v);
    if (sel == 0) en_a = v; else en_b = v;
  endtask

  // Timeline from the access rules: ACT at 0, READ after TRCD, CAS_LAT+BURST_LEN
  // wait cycles, PRECHARGE, TRP to END, data valid in the burst window.
  function automatic vec_t model_vec(input int sel, input logic [23:0] a, input int gdly,
                                     input bit tmid, input bit drop);
    vec_t v;
    int trcd, cl, bl, trp;
    trcd = (sel == 0) ? 2 : 3;
    cl   = (sel == 0) ? 3 : 2;
    bl   = (sel == 0) ? 8 : 4;
    trp  = 2;
    v.sel = sel; v.addr = a; v.gdly = gdly; v.tmid = tmid; v.drop = drop;
    v.ba  = a[23:22];
    v.row = a[21:9];
    v.col = a[8:0];
    v.rd_c  = trcd;
    v.pre_c = trcd + cl + bl + 1;
    v.end_c = v.pre_c + trp;
    v.vf    = trcd + cl + 1;
    v.vl    = trcd + cl + bl;
    return v;
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cmd"},   32'(m_cmd),   32'(NOP));
    chk({tag, "_ba"},    32'(m_ba),    32'h3);
    chk({tag, "_addr"},  32'(m_addr),  32'h1fff);
    chk({tag, "_req"},   32'(m_req),   32'h0);
    chk({tag, "_end"},   32'(m_end),   32'h0);
    chk({tag, "_busy"},  32'(m_busy),  32'h0);
    chk({tag, "_valid"}, 32'(m_valid), 32'h0);
    chk({tag, "_data"},  32'(m_data),  32'h0);
  endtask

  task automatic run_access(input vec_t v);
    logic [3:0]  e_cmd;
    logic [1:0]  e_ba;
    logic [12:0] e_addr;
    cur = v.sel;
    $display("access sel=%0d addr=%06h grant_delay=%0d trig_mid=%0d drop_en=%0d",
             v.sel, v.addr, v.gdly, v.tmid, v.drop);
    addr_in = v.addr;
    set_trig(v.sel, 1'b1);
    drive_dq();
    @(negedge clk);
    set_trig(v.sel, 1'b0);
    addr_in = 24'($urandom);
    chk("req_set", 32'(m_req), 32'h1);
    chk("busy_set", 32'(m_busy), 32'h1);
    chk("cmd_pending", 32'(m_cmd), 32'(NOP));
    drive_dq();
    for (int g = 0; g < v.gdly; g++) begin
      @(negedge clk);
      chk("req_wait", 32'(m_req), 32'h1);
      chk("cmd_wait", 32'(m_cmd), 32'(NOP));
      drive_dq();
    end
    set_en(v.sel, 1'b1);
    for (int k = 0; k <= v.end_c + 1; k++) begin
      @(negedge clk);
      e_cmd = NOP; e_ba = 2'b11; e_addr = 13'h1fff;
      if (k == 0) begin
        e_cmd = ACT; e_ba = v.ba; e_addr = v.row;
      end else if (k == v.rd_c) begin
        e_cmd = RD; e_ba = v.ba; e_addr = {4'b0000, v.col};
      end else if (k == v.pre_c) begin
        e_cmd = PRE; e_ba = v.ba; e_addr = 13'h0400;
      end
      chk($sformatf("cmd_c%0d", k),  32'(m_cmd),  32'(e_cmd));
      chk($sformatf("ba_c%0d", k),   32'(m_ba),   32'(e_ba));
      chk($sformatf("addr_c%0d", k), 32'(m_addr), 32'(e_addr));
      chk($sformatf("end_c%0d", k),  32'(m_end),  32'(k == v.end_c));
      chk($sformatf("busy_c%0d", k), 32'(m_busy), 32'(k <= v.end_c));
      chk($sformatf("req_c%0d", k),  32'(m_req),  32'h0);
      chk($sformatf("valid_c%0d", k), 32'(m_valid), 32'(k >= v.vf && k <= v.vl));
      if (k >= v.vf && k <= v.vl)
        chk($sformatf("data_c%0d", k), 32'(m_data), 32'(last_dq));
      set_trig(v.sel, v.tmid && k == 4);
      if (v.drop && k == 3) set_en(v.sel, 1'b0);
      if (k == v.end_c) set_en(v.sel, 1'b0);
      drive_dq();
    end
    set_en(v.sel, 1'b0);
    for (int p = 0; p < 4; p++) begin
      @(negedge clk);
      chk("post_req", 32'(m_req), 32'h0);
      chk("post_busy", 32'(m_busy), 32'h0);
      chk("post_cmd", 32'(m_cmd), 32'(NOP));
      drive_dq();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, {2'd1, 13'h0500, 9'h123}, 2, 1'b0, 1'b0, 2'd1, 13'h0500, 9'h123, 2, 14, 16, 6, 13};
    tbl[1] = '{0, {2'd2, 13'h1abc, 9'h1ff}, 0, 1'b1, 1'b0, 2'd2, 13'h1abc, 9'h1ff, 2, 14, 16, 6, 13};
    tbl[2] = '{0, {2'd3, 13'h0001, 9'h000}, 1, 1'b0, 1'b1, 2'd3, 13'h0001, 9'h000, 2, 14, 16, 6, 13};
    tbl[3] = '{1, {2'd0, 13'h1fff, 9'h0aa}, 0, 1'b0, 1'b0, 2'd0, 13'h1fff, 9'h0aa, 3, 10, 12, 6, 9};
    tbl[4] = '{1, {2'd1, 13'h0a5a, 9'h155}, 3, 1'b1, 1'b1, 2'd1, 13'h0a5a, 9'h155, 3, 10, 12, 6, 9};
    tbl[5] = '{0, {2'd0, 13'h0000, 9'h001}, 4, 1'b1, 1'b1, 2'd0, 13'h0000, 9'h001, 2, 14, 16, 6, 13};

    // Reset state
    repeat (3) @(negedge clk);
    cur = 0;
    check_reset_vals("rst_a");
    cur = 1;
    check_reset_vals("rst_b");
    rst = 1'b0;
    drive_dq();

    // Table-driven accesses
    for (int i = 0; i < 6; i++) run_access(tbl[i]);

    // Randomized accesses against the timeline model
    for (int i = 0; i < 8; i++) begin
      vec_t v;
      v = model_vec(int'($urandom_range(0, 1)), 24'($urandom), int'($urandom_range(0, 4)),
                    1'($urandom), 1'($urandom));
      run_access(v);
    end

    // Reset in the middle of the burst: immediate IDLE, no PRECHARGE
    cur = 0;
    $display("sequence reset_mid_burst");
    addr_in = {2'd2, 13'h0123, 9'h045};
    trig_a = 1'b1;
    @(negedge clk);
    trig_a = 1'b0;
    en_a = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      drive_dq();
    end
    chk("midburst_valid", 32'(m_valid), 32'h1);
    rst = 1'b1;
    en_a = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_reset_vals($sformatf("rstmid%0d", k));
      drive_dq();
    end
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("after_rst_cmd", 32'(m_cmd), 32'(NOP));
      chk("after_rst_busy", 32'(m_busy), 32'h0);
      drive_dq();
    end

    // No grant: request held, bus stays idle
    $display("sequence no_grant");
    addr_in = 24'h123456;
    trig_a = 1'b1;
    @(negedge clk);
    trig_a = 1'b0;
    for (int k = 0; k < 50; k++) begin
      chk("nogrant_req", 32'(m_req), 32'h1);
      chk("nogrant_cmd", 32'(m_cmd), 32'(NOP));
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("nogrant_cleared", 32'(m_req), 32'h0);

    // init_end low: trigger ignored
    $display("sequence init_end_low");
    init_end = 1'b0;
    trig_a = 1'b1;
    en_a = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("noinit_req", 32'(m_req), 32'h0);
      chk("noinit_busy", 32'(m_busy), 32'h0);
      chk("noinit_cmd", 32'(m_cmd), 32'(NOP));
    end
    trig_a = 1'b0;
    en_a = 1'b0;
    init_end = 1'b1;
    @(negedge clk);

    // Engine still usable afterwards
    run_access(tbl[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
